// File: rtl/isp_ae_stats.sv
// Auto-exposure statistics: 1-cycle pixel passthrough, per-frame luma sums,
// restoring-divider mean. Optional clip counters: ISP_AE_CLIP_COUNT_EN.
module isp_ae_stats #(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 24
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     in_href,
  input  logic                     in_vsync,
  input  logic [BITS-1:0]          in_data,
  input  logic [BITS-1:0]          dark_thr,
  input  logic [BITS-1:0]          bright_thr,
  output logic                     out_href,
  output logic                     out_vsync,
  output logic [BITS-1:0]          out_data,
  output logic [BITS+CNT_BITS-1:0] stats_sum,
  output logic [CNT_BITS-1:0]      stats_cnt,
  output logic [BITS-1:0]          stats_mean,
  output logic [CNT_BITS-1:0]      stats_dark,
  output logic [CNT_BITS-1:0]      stats_bright,
  output logic                     stats_valid,
  output logic                     stats_overrun
);

  localparam int DW = BITS + CNT_BITS;
  localparam int IW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                vs_q;
  logic                frame_end;
  logic [DW-1:0]       acc_sum, base_sum, sum_nx, snap_sum;
  logic [DW:0]         sum_add;
  logic [CNT_BITS-1:0] acc_cnt, base_cnt, cnt_nx, snap_cnt;
  logic [IW-1:0]       iter;
  logic [DW-1:0]       quo;
  logic [CNT_BITS-1:0] rem, rem_nx;
  logic [CNT_BITS:0]   trial, diff;
  logic                take;
  logic [BITS-1:0]     mean_nx;

  assign frame_end = in_vsync & ~vs_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_data  <= '0;
      vs_q      <= 1'b0;
    end else begin
      out_href  <= in_href;
      out_vsync <= in_vsync;
      out_data  <= in_data;
      vs_q      <= in_vsync;
    end
  end

  // A frame end restarts the accumulators from zero, seeded by this pixel.
  always_comb begin
    base_sum = frame_end ? '0 : acc_sum;
    base_cnt = frame_end ? '0 : acc_cnt;
    sum_add  = {1'b0, base_sum} + {{(CNT_BITS + 1){1'b0}}, in_data};
    sum_nx   = base_sum;
    cnt_nx   = base_cnt;
    if (in_href) begin
      sum_nx = sum_add[DW] ? '1 : sum_add[DW-1:0];
      if (!(&base_cnt)) cnt_nx = base_cnt + CNT_BITS'(1);
    end
  end

  assign trial  = {rem, quo[DW-1]};
  assign diff   = trial - {1'b0, snap_cnt};
  assign take   = trial >= {1'b0, snap_cnt};
  assign rem_nx = take ? diff[CNT_BITS-1:0] : trial[CNT_BITS-1:0];

  always_comb begin
    mean_nx = quo[BITS-1:0];
    if (|quo[DW-1:BITS]) mean_nx = '1;
    if (snap_cnt == '0)  mean_nx = '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = IDLE;
      DIV:  if (iter == IW'(DW - 1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (frame_end) state_nx = DIV;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum  <= '0;
      acc_cnt  <= '0;
      snap_sum <= '0;
      snap_cnt <= '0;
      quo      <= '0;
      rem      <= '0;
      iter     <= '0;
    end else begin
      acc_sum <= sum_nx;
      acc_cnt <= cnt_nx;
      if (frame_end) begin
        snap_sum <= acc_sum;
        snap_cnt <= acc_cnt;
        quo      <= acc_sum;
        rem      <= '0;
        iter     <= '0;
      end else if (state == DIV) begin
        quo  <= {quo[DW-2:0], take};
        rem  <= rem_nx;
        iter <= iter + IW'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      stats_sum     <= '0;
      stats_cnt     <= '0;
      stats_mean    <= '0;
      stats_valid   <= 1'b0;
      stats_overrun <= 1'b0;
    end else begin
      stats_valid   <= (state == DONE);
      stats_overrun <= frame_end && (state == DIV);
      if (state == DONE) begin
        stats_sum  <= snap_sum;
        stats_cnt  <= snap_cnt;
        stats_mean <= mean_nx;
      end
    end
  end

`ifdef ISP_AE_CLIP_COUNT_EN
  logic [CNT_BITS-1:0] acc_dark, acc_bright;
  logic [CNT_BITS-1:0] base_dark, base_bright;
  logic [CNT_BITS-1:0] dark_nx, bright_nx;
  logic [CNT_BITS-1:0] snap_dark, snap_bright;

  always_comb begin
    base_dark   = frame_end ? '0 : acc_dark;
    base_bright = frame_end ? '0 : acc_bright;
    dark_nx     = base_dark;
    bright_nx   = base_bright;
    if (in_href && in_data < dark_thr && !(&base_dark))
      dark_nx = base_dark + CNT_BITS'(1);
    if (in_href && in_data > bright_thr && !(&base_bright))
      bright_nx = base_bright + CNT_BITS'(1);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_dark     <= '0;
      acc_bright   <= '0;
      snap_dark    <= '0;
      snap_bright  <= '0;
      stats_dark   <= '0;
      stats_bright <= '0;
    end else begin
      acc_dark   <= dark_nx;
      acc_bright <= bright_nx;
      if (frame_end) begin
        snap_dark   <= acc_dark;
        snap_bright <= acc_bright;
      end
      if (state == DONE) begin
        stats_dark   <= snap_dark;
        stats_bright <= snap_bright;
      end
    end
  end
`else
  logic unused_thr;
  assign unused_thr   = ^{dark_thr, bright_thr};
  assign stats_dark   = '0;
  assign stats_bright = '0;
`endif

endmodule
